// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues two-word I-cache requests at the current PC,
// pushes returned words into the instruction queue and squashes fetches on redirect.
module fetch_ctrl #(
   parameter int QFREE_W = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [31:0]        pc,
   input  logic               redirect,
   output logic               req_valid,
   output logic [31:0]        req_addr,
   input  logic               req_ready,
   input  logic               resp_valid,
   input  logic [31:0]        resp_data0,
   input  logic [31:0]        resp_data1,
   input  logic               resp_v2,
   input  logic [QFREE_W-1:0] q_free,
   output logic [1:0]         q_push,
   output logic [31:0]        q_inst0,
   output logic [31:0]        q_inst1,
   output logic [31:0]        q_pc0,
   output logic [31:0]        q_pc1,
   output logic               adv1,
   output logic               adv2,
   output logic               full
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] fa_q, fa_d;
   logic        room;

   // Two slots are reserved per group, so a request needs at least two free entries.
   assign room     = (q_free >= QFREE_W'(2));
   assign full     = ~room;
   assign req_addr = pc;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         fa_q    <= '0;
      end else begin
         state_q <= state_d;
         fa_q    <= fa_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fa_d      = fa_q;
      req_valid = 1'b0;
      q_push    = 2'd0;
      q_inst0   = '0;
      q_inst1   = '0;
      q_pc0     = '0;
      q_pc1     = '0;
      adv1      = 1'b0;
      adv2      = 1'b0;
      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            // A redirecting cycle carries a stale pc, so nothing is requested.
            req_valid = ~redirect & room;
            if (req_valid && req_ready) begin
               fa_d    = pc;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (resp_valid && !redirect) begin
               q_push  = resp_v2 ? 2'd2 : 2'd1;
               q_inst0 = resp_data0;
               q_inst1 = resp_data1;
               q_pc0   = fa_q;
               q_pc1   = fa_q + 32'd4;
               adv1    = 1'b1;
               adv2    = resp_v2;
               state_d = S_REQ;
            end else if (resp_valid) begin
               state_d = S_REQ;
            end else if (redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (resp_valid) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, state advances on the rising edge.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] pc;
   logic        redirect;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data0, resp_data1;
   logic        resp_v2;
   logic [3:0]  q_free;
   logic [1:0]  q_push;
   logic [31:0] q_inst0, q_inst1, q_pc0, q_pc1;
   logic        adv1, adv2, full;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.QFREE_W(4)) dut (
      .clk(clk), .resetn(resetn), .pc(pc), .redirect(redirect),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data0(resp_data0), .resp_data1(resp_data1),
      .resp_v2(resp_v2), .q_free(q_free), .q_push(q_push),
      .q_inst0(q_inst0), .q_inst1(q_inst1), .q_pc0(q_pc0), .q_pc1(q_pc1),
      .adv1(adv1), .adv2(adv2), .full(full)
   );

   task automatic test_reset();
      resetn = 1'b0; pc = 32'hbfc00000; redirect = 1'b0; req_ready = 1'b1;
      resp_valid = 1'b0; resp_data0 = 32'h0; resp_data1 = 32'h0; resp_v2 = 1'b1;
      q_free = 4'd8;
      @(negedge clk); #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", req_valid); end
      total++; if (req_addr !== 32'hbfc00000) begin bad++; $display("FAIL rst_req_addr got=%h exp=bfc00000", req_addr); end
      total++; if (q_push !== 2'd0) begin bad++; $display("FAIL rst_q_push got=%0d exp=0", q_push); end
      total++; if ({adv1, adv2} !== 2'b00) begin bad++; $display("FAIL rst_adv got=%b exp=00", {adv1, adv2}); end
      total++; if (q_pc0 !== 32'h0 || q_inst0 !== 32'h0) begin bad++; $display("FAIL rst_q_out got=%h/%h exp=0/0", q_pc0, q_inst0); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full_q8 got=%b exp=0", full); end
      q_free = 4'd1; #1;
      total++; if (full !== 1'b1) begin bad++; $display("FAIL rst_full_q1 got=%b exp=1", full); end
      q_free = 4'd8;
   endtask

   task automatic test_first_fetch();
      @(negedge clk); resetn = 1'b1; #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL idle_req_valid got=%b exp=0", req_valid); end
      @(negedge clk); #1;
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%b exp=1", req_valid); end
      total++; if (req_addr !== 32'hbfc00000) begin bad++; $display("FAIL first_req_addr got=%h exp=bfc00000", req_addr); end
      @(negedge clk);
      resp_valid = 1'b1; resp_v2 = 1'b1; resp_data0 = 32'h11110000; resp_data1 = 32'h22220004; #1;
      total++; if (q_push !== 2'd2) begin bad++; $display("FAIL first_q_push got=%0d exp=2", q_push); end
      total++; if (q_pc0 !== 32'hbfc00000) begin bad++; $display("FAIL first_q_pc0 got=%h exp=bfc00000", q_pc0); end
      total++; if (q_pc1 !== 32'hbfc00004) begin bad++; $display("FAIL first_q_pc1 got=%h exp=bfc00004", q_pc1); end
      total++; if (q_inst0 !== 32'h11110000 || q_inst1 !== 32'h22220004) begin bad++; $display("FAIL first_q_inst got=%h/%h exp=11110000/22220004", q_inst0, q_inst1); end
      total++; if ({adv1, adv2} !== 2'b11) begin bad++; $display("FAIL first_adv got=%b exp=11", {adv1, adv2}); end
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL first_wait_req got=%b exp=0", req_valid); end
      @(negedge clk); resp_valid = 1'b0; pc = 32'hbfc00008; #1;
      total++; if (req_valid !== 1'b1 || req_addr !== 32'hbfc00008) begin bad++; $display("FAIL second_req got=%b/%h exp=1/bfc00008", req_valid, req_addr); end
   endtask

   task automatic test_single_word();
      // Previous request at bfc00008 is in flight; answer it, then fetch the line end.
      @(negedge clk); resp_valid = 1'b1; resp_v2 = 1'b1;
      @(negedge clk); resp_valid = 1'b0; pc = 32'hbfc0001c; #1;
      total++; if (req_valid !== 1'b1 || req_addr !== 32'hbfc0001c) begin bad++; $display("FAIL line_end_req got=%b/%h exp=1/bfc0001c", req_valid, req_addr); end
      @(negedge clk); resp_valid = 1'b1; resp_v2 = 1'b0; resp_data0 = 32'h3333001c; #1;
      total++; if (q_push !== 2'd1) begin bad++; $display("FAIL single_q_push got=%0d exp=1", q_push); end
      total++; if ({adv1, adv2} !== 2'b10) begin bad++; $display("FAIL single_adv got=%b exp=10", {adv1, adv2}); end
      total++; if (q_pc0 !== 32'hbfc0001c || q_inst0 !== 32'h3333001c) begin bad++; $display("FAIL single_q0 got=%h/%h exp=bfc0001c/3333001c", q_pc0, q_inst0); end
      @(negedge clk); resp_valid = 1'b0; resp_v2 = 1'b1; pc = 32'hbfc00020; q_free = 4'd1; #1;
      total++; if (req_addr !== 32'hbfc00020) begin bad++; $display("FAIL single_next_addr got=%h exp=bfc00020", req_addr); end
   endtask

   task automatic test_queue_full();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         total++; if (full !== 1'b1 || req_valid !== 1'b0) begin bad++; $display("FAIL qfull_hold%0d got=%b/%b exp=1/0", i, full, req_valid); end
      end
      q_free = 4'd2; #1;
      total++; if (full !== 1'b0 || req_valid !== 1'b1) begin bad++; $display("FAIL qfree2_req got=%b/%b exp=0/1", full, req_valid); end
      @(negedge clk); resp_valid = 1'b1; q_free = 4'd8; #1;
      total++; if (q_push !== 2'd2 || q_pc1 !== 32'hbfc00024) begin bad++; $display("FAIL qfree2_push got=%0d/%h exp=2/bfc00024", q_push, q_pc1); end
   endtask

   task automatic test_redirect_wait();
      @(negedge clk); resp_valid = 1'b0; pc = 32'h00000100; #1;
      total++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin bad++; $display("FAIL rdw_req got=%b/%h exp=1/00000100", req_valid, req_addr); end
      @(negedge clk); redirect = 1'b1; #1;
      total++; if (req_valid !== 1'b0 || q_push !== 2'd0) begin bad++; $display("FAIL rdw_redirect got=%b/%0d exp=0/0", req_valid, q_push); end
      @(negedge clk); redirect = 1'b0; pc = 32'h00002000; #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rdw_drop_req got=%b exp=0", req_valid); end
      @(negedge clk); resp_valid = 1'b1; resp_v2 = 1'b1; #1;
      total++; if (q_push !== 2'd0 || {adv1, adv2} !== 2'b00 || req_valid !== 1'b0) begin bad++; $display("FAIL rdw_stale got=%0d/%b/%b exp=0/00/0", q_push, {adv1, adv2}, req_valid); end
      @(negedge clk); resp_valid = 1'b0; #1;
      total++; if (req_valid !== 1'b1 || req_addr !== 32'h2000) begin bad++; $display("FAIL rdw_after got=%b/%h exp=1/00002000", req_valid, req_addr); end
   endtask

   task automatic test_redirect_coincident();
      @(negedge clk); redirect = 1'b1; resp_valid = 1'b1; resp_v2 = 1'b1; #1;
      total++; if (q_push !== 2'd0 || {adv1, adv2} !== 2'b00) begin bad++; $display("FAIL coin_push got=%0d/%b exp=0/00", q_push, {adv1, adv2}); end
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL coin_req got=%b exp=0", req_valid); end
      @(negedge clk); redirect = 1'b0; resp_valid = 1'b0; pc = 32'h00003000; #1;
      total++; if (req_valid !== 1'b1 || req_addr !== 32'h3000) begin bad++; $display("FAIL coin_next got=%b/%h exp=1/00003000", req_valid, req_addr); end
   endtask

   task automatic test_async_reset();
      @(negedge clk); resp_valid = 1'b1; resp_v2 = 1'b1; #1;
      total++; if (q_push !== 2'd2 || q_pc0 !== 32'h3000) begin bad++; $display("FAIL ar_pre_push got=%0d/%h exp=2/00003000", q_push, q_pc0); end
      #1 resetn = 1'b0; #1;
      total++; if (q_push !== 2'd0 || {adv1, adv2} !== 2'b00 || req_valid !== 1'b0) begin bad++; $display("FAIL ar_async got=%0d/%b/%b exp=0/00/0", q_push, {adv1, adv2}, req_valid); end
      resp_valid = 1'b0;
      @(negedge clk); resetn = 1'b1; resp_valid = 1'b1; #1;
      total++; if (q_push !== 2'd0 || adv1 !== 1'b0) begin bad++; $display("FAIL ar_stale_idle got=%0d/%b exp=0/0", q_push, adv1); end
      @(negedge clk); req_ready = 1'b0; #1;
      total++; if (q_push !== 2'd0 || adv1 !== 1'b0 || req_valid !== 1'b1) begin bad++; $display("FAIL ar_stale_req got=%0d/%b/%b exp=0/0/1", q_push, adv1, req_valid); end
      @(negedge clk); resp_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_single_word();
      test_queue_full();
      test_redirect_wait();
      test_redirect_coincident();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the fetch PC register and the instruction cache read port. It issues one two-word fetch request per group at the current PC and tracks the single outstanding request. It pushes the returned words, tagged with their addresses, into the instruction queue, and pulses the PC advance inputs (`i_ready_1` / `i_ready_2`). It squashes in-flight fetches on branch/exception redirect and raises `full` when the queue cannot accept a group.

## Interface
- `QFREE_W`, default 4: width of the queue free-slot count.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `pc` in 32: current fetch PC from the PC register.
- `redirect` in 1: `is_branch | is_exception` this cycle; PC takes the new target at the next edge.
- `req_valid` out 1: fetch request to the I-cache.
- `req_addr` out 32: request address; equals `pc`.
- `req_ready` in 1: the I-cache accepts the request this cycle.
- `resp_valid` in 1: response for the outstanding request (one-cycle pulse).
- `resp_data0`, `resp_data1` in 32 each: words at `addr` and `addr+4`.
- `resp_v2` in 1: `resp_data1` is valid (same cache line).
- `q_free` in QFREE_W: free instruction-queue slots.
- `q_push` out 2: number of entries pushed this cycle (0, 1 or 2).
- `q_inst0`, `q_inst1` out 32 each: pushed instructions.
- `q_pc0`, `q_pc1` out 32 each: their addresses.
- `adv1`, `adv2` out 1 each: drive PC `i_ready_1` / `i_ready_2`.
- `full` out 1: drives PC `full`; `full = (q_free < 2)`, combinational.

## Operation
- States are IDLE, REQ, WAIT and DROP. Async reset forces IDLE and clears the latched address `fa`.
- **IDLE**
  - Used only after reset; goes to REQ the next cycle unconditionally.
  - All request and push outputs are 0.
- **REQ**
  - `req_valid = !redirect && q_free >= 2`.
  - `req_addr = pc`.
  - On `req_valid && req_ready`: latch `fa = pc` and go to WAIT.
  - If `redirect` is high, no request is made and the state stays REQ; the new PC is fetched next cycle.
- **WAIT**
  - On `resp_valid && !redirect`:
    - `q_push = resp_v2 ? 2 : 1`.
    - `q_inst0 = resp_data0`, `q_pc0 = fa`.
    - `q_inst1 = resp_data1`, `q_pc1 = fa + 4` (32-bit wrap).
    - `adv1 = 1`, `adv2 = resp_v2`.
    - Go to REQ.
  - On `redirect && resp_valid`: discard the response, no push, no advance; go to REQ.
  - On `redirect && !resp_valid`: go to DROP.
- **DROP**
  - Waits for the stale response; all outputs are 0.
  - On `resp_valid`: discard it and go to REQ.
  - A `redirect` in DROP has no additional effect.
- At most one request is outstanding.
- Two queue slots are reserved at request time. Only this block pushes, so `q_free` cannot fall below 2 before the response.
- When not pushing, `q_inst*` and `q_pc*` are don't-care and `q_push = 0`.

## Timing
- Reset values: `req_valid = 0`, `req_addr = pc`, `q_push = 0`, `adv1 = 0`, `adv2 = 0`, `q_* = 0`. `full` follows `q_free` even while in reset.
- Request accepted at edge t; response earliest at cycle t+1.
- Push and advance happen in the same cycle as `resp_valid` (zero added latency).
- The PC updates at the following edge, and the next `req_valid` can assert in that cycle.
- Minimum two cycles per group with a 1-cycle cache.
- A `redirect` in a cycle blocks `req_valid` that cycle, because `pc` is stale.
- Every response that follows a redirect never produces a push or advance.
- `resetn` asserted mid-WAIT: back to IDLE immediately. A later stale `resp_valid` arriving in IDLE or REQ is ignored; it is never pushed because only WAIT pushes.

## Test plan
- **Reset and first fetch:** release reset with `pc = 0xbfc00000`, `q_free = 8`, cache ready with 1-cycle latency, `resp_v2 = 1`.
  - Expect IDLE for 1 cycle, then `req_valid` with `req_addr = 0xbfc00000`.
  - Next cycle: `q_push = 2`, `q_pc0 = 0xbfc00000`, `q_pc1 = 0xbfc00004`, `adv1 = adv2 = 1`.
  - Next request at `0xbfc00008`.
- **Single word at line end:** `pc = 0xbfc0001c`, `resp_v2 = 0`.
  - Expect `q_push = 1`, `adv1 = 1`, `adv2 = 0`, and next `req_addr = 0xbfc00020`.
- **Queue nearly full:** `q_free = 1`.
  - Expect `full = 1` and `req_valid = 0` for as long as it is held.
  - Raise `q_free` to 2: `req_valid` asserts that cycle.
- **Redirect while waiting:** request to `0x100` accepted, then `redirect` the next cycle with the response delayed 3 cycles.
  - Expect DROP, the response discarded, no push.
  - `req_addr` equals the redirected `pc` after the stale response.
- **Redirect coincident with response:** `redirect` and `resp_valid` in the same cycle.
  - Expect `q_push = 0`, `adv1 = 0`.
  - Next cycle `req_valid` at the new `pc`.
- **Async reset mid-WAIT:** drop `resetn` between edges.
  - `req_valid`, `q_push` and `adv*` go to 0 without a clock edge.
  - A stale response after release is not pushed.
